// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: widths, mode defaults and FSM encoding.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 8;
    localparam int unsigned CNT_W     = 4;

    localparam logic [CNT_W-1:0] E_LAST = '1;

    localparam logic CPOL_DEFAULT = 1'b1;
    localparam logic CPHA_DEFAULT = 1'b1;

    typedef enum logic [1:0] {
        S0_IDLE   = 2'd0,
        S1_LOAD   = 2'd1,
        S2_ACTIVE = 2'd2,
        S3_DONE   = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus registered rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_q;
    logic fall_q;

    // Synchronize the pin, keep the previous level and register edge pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            s3_q   <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled cs/sclk/mosi, byte receive and transmit, all four modes.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic CPOL = CPOL_DEFAULT,
    parameter logic CPHA = CPHA_DEFAULT
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [SPI_WIDTH-1:0] data_tx,
    output logic                 tx_load,
    output logic [SPI_WIDTH-1:0] data_rx,
    output logic                 rx_valid,
    output logic                 busy
);

    logic cs_rise;
    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;

    logic mosi_s1_q;
    logic mosi_s2_q;

    spi_state_e           state_q,    state_d;
    logic [CNT_W-1:0]     e_q,        e_d;
    logic [SPI_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_WIDTH-1:0] data_rx_q,  data_rx_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_load_q,  tx_load_d;
    logic                 busy_q,     busy_d;
    logic                 miso_q,     miso_d;

    logic sclk_edge;
    logic do_sample;
    logic do_shift;

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Next-state, shift and output logic; outputs are derived from the next state.
    always_comb begin
        state_d    = state_q;
        e_d        = e_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        data_rx_d  = data_rx_q;

        sclk_edge = sclk_rise | sclk_fall;
        do_sample = CPHA ? e_q[0] : ~e_q[0];
        do_shift  = CPHA ? (~e_q[0] && (e_q != '0)) : (e_q[0] && (e_q != E_LAST));

        case (state_q)
            S0_IDLE: begin
                e_d = '0;
                if (cs_fall) begin
                    state_d = S1_LOAD;
                end
            end
            S1_LOAD: begin
                tx_shift_d = data_tx;
                rx_shift_d = '0;
                e_d        = '0;
                state_d    = S2_ACTIVE;
            end
            S2_ACTIVE: begin
                if (sclk_edge) begin
                    e_d = e_q + CNT_W'(1);
                    if (do_sample) begin
                        rx_shift_d = {rx_shift_q[SPI_WIDTH-2:0], mosi_s2_q};
                    end
                    if (do_shift) begin
                        tx_shift_d = {tx_shift_q[SPI_WIDTH-2:0], 1'b0};
                    end
                    if (e_q == E_LAST) begin
                        state_d = S3_DONE;
                    end
                end
            end
            S3_DONE: begin
                tx_shift_d = data_tx;
                rx_shift_d = '0;
                e_d        = '0;
                state_d    = cs_rise ? S0_IDLE : S2_ACTIVE;
            end
            default: begin
                state_d = S0_IDLE;
            end
        endcase

        // Deselect aborts any partial byte; a completing byte still reports first.
        if (cs_rise && (state_q != S3_DONE)) begin
            state_d = S0_IDLE;
            e_d     = '0;
        end

        rx_valid_d = (state_d == S3_DONE);
        if (rx_valid_d) begin
            data_rx_d = rx_shift_d;
        end
        tx_load_d = (state_d == S1_LOAD) || (state_d == S3_DONE);
        busy_d    = (state_d != S0_IDLE);
        miso_d    = ((state_d == S2_ACTIVE) || (state_d == S3_DONE)) ?
                    tx_shift_d[SPI_WIDTH-1] : 1'b1;
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            state_q    <= S0_IDLE;
            e_q        <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            data_rx_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            miso_q     <= 1'b1;
        end else begin
            mosi_s1_q  <= mosi;
            mosi_s2_q  <= mosi_s1_q;
            state_q    <= state_d;
            e_q        <= e_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            data_rx_q  <= data_rx_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            busy_q     <= busy_d;
            miso_q     <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign data_rx  = data_rx_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign busy     = busy_q;

endmodule
